// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity modes, tx FSM states, bit-period math.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

  // Parity selection, encoded to match the PARITY parameter values.
  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  // Transmitter frame states. Three bits leave unused encodings,
  // which the FSM treats as a fault and recovers from.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  // Clock cycles per line bit, truncated. Shared with the receiver so both
  // sides of the link derive the same bit period from the same parameters.
  function automatic int calc_pulse_width(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: reload on i_load, o_bit_end while the count reads 0.
// Latency: i_load takes effect next edge; a bit spans exactly PULSE_WIDTH cycles.
// Backpressure: none; the counter free-runs down and parks at 0.
module uart_baud_cnt #(
  parameter int PULSE_WIDTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_bit_end
);

  localparam int CW = $clog2(PULSE_WIDTH) + 1;

  logic [CW-1:0] r_cnt;

  // Reload at each bit boundary, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(PULSE_WIDTH - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // The current bit ends on the cycle the count reads zero.
  assign o_bit_end = (r_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, 1-2 stop bits.
// Latency: word accepted at edge k drives the start bit from edge k+1; frames chain with no gap.
// Backpressure: in_ready drops while the one-entry holding buffer is full or rst is high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx_sig,
  output logic                  tx_busy
);

  localparam int      PULSE_WIDTH = calc_pulse_width(CLK_FREQ, BAUD_RATE);
  // Counts data bits, and is reused to count stop bits.
  localparam int      BCW         = $clog2(DATA_WIDTH) + 1;
  localparam parity_e PAR_MODE    = parity_e'(PARITY[1:0]);

  // Reject configurations the frame logic cannot represent.
  if (PULSE_WIDTH < 2) begin : g_chk_pulse
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end

  // Frame state
  tx_state_e             r_state;
  tx_state_e             w_state_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DATA_WIDTH-1:0] w_shift_sh;
  logic                  r_par;
  logic                  w_par_nxt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [BCW-1:0]        w_bit_cnt_nxt;

  // Holding buffer
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_buf_vld;
  logic                  w_buf_par;

  // Control
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_load;
  logic                  w_bit_end;

  assign in_ready   = !r_buf_vld && !rst;
  assign w_accept   = in_valid && in_ready;
  assign tx_busy    = ((r_state != S_IDLE) || r_buf_vld) && !rst;
  assign tx_sig     = r_tx;
  assign w_shift_sh = r_shift >> 1;
  // Parity is taken from the whole word as it leaves the buffer.
  assign w_buf_par  = (PAR_MODE == PAR_ODD) ? ~(^r_buf) : (^r_buf);

  uart_baud_cnt #(
    .PULSE_WIDTH (PULSE_WIDTH)
  ) u_baud_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .o_bit_end (w_bit_end)
  );

  // Holding buffer: capture on handshake, release when the FSM drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf     <= '0;
      r_buf_vld <= 1'b0;
    end else if (w_accept) begin
      r_buf     <= in_data;
      r_buf_vld <= 1'b1;
    end else if (w_drain) begin
      r_buf_vld <= 1'b0;
    end
  end

  // FSM and datapath registers; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_shift   <= w_shift_nxt;
      r_par     <= w_par_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Next-state and line-level logic; every bit boundary reloads the baud counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par;
    w_bit_cnt_nxt = r_bit_cnt;
    w_drain       = 1'b0;
    w_load        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (r_buf_vld) begin
          w_drain       = 1'b1;
          w_load        = 1'b1;
          w_shift_nxt   = r_buf;
          w_par_nxt     = w_buf_par;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = 1'b0;
          w_state_nxt   = S_START;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_load        = 1'b1;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = r_shift[0];
          w_state_nxt   = S_DATA;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_load = 1'b1;
          if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
            w_bit_cnt_nxt = '0;
            if (PAR_MODE != PAR_NONE) begin
              w_tx_nxt    = r_par;
              w_state_nxt = S_PARITY;
            end else begin
              w_tx_nxt    = 1'b1;
              w_state_nxt = S_STOP;
            end
          end else begin
            w_shift_nxt   = w_shift_sh;
            w_tx_nxt      = w_shift_sh[0];
            w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          end
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_load        = 1'b1;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = 1'b1;
          w_state_nxt   = S_STOP;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BCW'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when a word is waiting.
            if (r_buf_vld) begin
              w_drain       = 1'b1;
              w_load        = 1'b1;
              w_shift_nxt   = r_buf;
              w_par_nxt     = w_buf_par;
              w_bit_cnt_nxt = '0;
              w_tx_nxt      = 1'b0;
              w_state_nxt   = S_START;
            end else begin
              w_bit_cnt_nxt = '0;
              w_tx_nxt      = 1'b1;
              w_state_nxt   = S_IDLE;
            end
          end else begin
            w_load        = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
            w_tx_nxt      = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_tx_nxt      = 1'b1;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8E2) at 10 clocks per bit.
// Line waveforms are captured cycle by cycle and compared against a frame model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int PW       = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_valid;
  logic [7:0] in_data [4];
  wire  [3:0] in_ready;
  wire  [3:0] tx_sig;
  wire  [3:0] tx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ), .STOP_BITS(1), .PARITY(0)) u_dut_8n1 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx_sig(tx_sig[0]), .tx_busy(tx_busy[0]));
  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ), .STOP_BITS(1), .PARITY(2)) u_dut_8e1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx_sig(tx_sig[1]), .tx_busy(tx_busy[1]));
  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ), .STOP_BITS(1), .PARITY(1)) u_dut_8o1 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .tx_sig(tx_sig[2]), .tx_busy(tx_busy[2]));
  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ), .STOP_BITS(2), .PARITY(2)) u_dut_8e2 (
    .clk(clk), .rst(rst), .in_data(in_data[3]), .in_valid(in_valid[3]),
    .in_ready(in_ready[3]), .tx_sig(tx_sig[3]), .tx_busy(tx_busy[3]));

  // Configuration of each instance
  function automatic int par_of(input int idx);
    case (idx)
      1:       return 2;
      2:       return 1;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int idx);
    return (1 + 8 + ((par_of(idx) != 0) ? 1 : 0) + stop_of(idx)) * PW;
  endfunction

  // Reference frame: list of bit levels, each stretched to PW cycles.
  // Bit c of the result is the line level in cycle c of the frame.
  function automatic logic [511:0] frame_model(input int idx, input logic [7:0] w);
    bit             lv[$];
    logic [511:0]   v;
    int             ones;
    v    = '0;
    ones = $countones(w);
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(w[i]);
    if (par_of(idx) == 2)      lv.push_back((ones % 2) == 1);
    else if (par_of(idx) == 1) lv.push_back((ones % 2) == 0);
    for (int s = 0; s < stop_of(idx); s++) lv.push_back(1'b1);
    for (int c = 0; c < lv.size() * PW; c++) v[c] = lv[c / PW];
    return v;
  endfunction

  function automatic logic [511:0] ones_range(input int lo, input int hi);
    logic [511:0] v;
    v = '0;
    for (int c = lo; c < hi; c++) v[c] = 1'b1;
    return v;
  endfunction

  // Offer a word and hold it until taken; returns on the falling edge after the transfer.
  task automatic push(input int idx, input logic [7:0] w);
    int t;
    t = 0;
    in_data[idx]  = w;
    in_valid[idx] = 1'b1;
    while (!in_ready[idx] && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 500) begin
      n_fail++;
      $display("FAIL push_timeout dut%0d word=%02h: in_ready=%b never rose (required 1)", idx, w, in_ready[idx]);
    end else begin
      @(negedge clk);
    end
    in_valid[idx] = 1'b0;
  endtask

  // Sample n cycles of line, busy and ready, one per falling edge.
  task automatic capture(input int idx, input int n,
                         output logic [511:0] tv, output logic [511:0] bv, output logic [511:0] rv);
    tv = '0;
    bv = '0;
    rv = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tv[c] = tx_sig[idx];
      bv[c] = tx_busy[idx];
      rv[c] = in_ready[idx];
    end
  endtask

  task automatic check_idle(input string name, input int idx);
    n_checks++;
    if (tx_busy[idx] !== 1'b0 || tx_sig[idx] !== 1'b1 || in_ready[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s dut%0d: busy=%b tx=%b ready=%b, required busy=0 tx=1 ready=1",
               name, idx, tx_busy[idx], tx_sig[idx], in_ready[idx]);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = '0;
    for (int i = 0; i < 4; i++) in_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_sig !== 4'hF || in_ready !== 4'h0 || tx_busy !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b, required tx=1111 ready=0000 busy=0000",
               tx_sig, in_ready, tx_busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_sig !== 4'hF || in_ready !== 4'hF || tx_busy !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_release: tx=%b ready=%b busy=%b, required tx=1111 ready=1111 busy=0000",
               tx_sig, in_ready, tx_busy);
    end
  endtask

  task automatic test_single(input int idx, input logic [7:0] w, output logic [511:0] tv);
    logic [511:0] bv, rv, exp;
    int n;
    n = frame_len(idx);
    push(idx, w);
    n_checks++;
    if (tx_sig[idx] !== 1'b1 || tx_busy[idx] !== 1'b1 || in_ready[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept dut%0d: tx=%b busy=%b ready=%b, required tx=1 busy=1 ready=0",
               idx, tx_sig[idx], tx_busy[idx], in_ready[idx]);
    end
    capture(idx, n, tv, bv, rv);
    exp = frame_model(idx, w);
    n_checks++;
    if (tv !== exp) begin
      n_fail++;
      $display("FAIL single_frame dut%0d word=%02h got=%h exp=%h", idx, w, tv, exp);
    end
    n_checks++;
    if (bv !== ones_range(0, n)) begin
      n_fail++;
      $display("FAIL single_busy dut%0d word=%02h got=%h exp=%h", idx, w, bv, ones_range(0, n));
    end
    @(negedge clk);
    check_idle("single_idle", idx);
  endtask

  task automatic test_parity();
    logic [511:0] tv;
    // Even parity on 0x07 (three ones) sends 1
    test_single(1, 8'h07, tv);
    n_checks++;
    if (tv[9*PW + PW/2] !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_even_07: bit=%b, required 1", tv[9*PW + PW/2]);
    end
    // Odd parity on 0x07 sends 0
    test_single(2, 8'h07, tv);
    n_checks++;
    if (tv[9*PW + PW/2] !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_odd_07: bit=%b, required 0", tv[9*PW + PW/2]);
    end
    // Even parity, two stop bits, 0x00: parity 0, twenty high stop cycles
    test_single(3, 8'h00, tv);
    n_checks++;
    if (tv[9*PW + PW/2] !== 1'b0 || tv[119:100] !== 20'hFFFFF) begin
      n_fail++;
      $display("FAIL parity_even2_00: parity=%b stop=%h, required parity=0 stop=fffff",
               tv[9*PW + PW/2], tv[119:100]);
    end
  endtask

  task automatic test_back_to_back(input int idx, input logic [7:0] w0, input logic [7:0] w1);
    logic [511:0] tv, bv, rv, exp;
    int l, n;
    l = frame_len(idx);
    n = 2 * l;
    fork
      begin
        push(idx, w0);
        push(idx, w1);
      end
      begin
        @(negedge clk);
        capture(idx, n, tv, bv, rv);
      end
    join
    exp = frame_model(idx, w0) | (frame_model(idx, w1) << l);
    n_checks++;
    if (tv !== exp) begin
      n_fail++;
      $display("FAIL b2b_frame dut%0d words=%02h,%02h got=%h exp=%h", idx, w0, w1, tv, exp);
    end
    n_checks++;
    if (bv !== ones_range(0, n)) begin
      n_fail++;
      $display("FAIL b2b_busy dut%0d got=%h exp=%h", idx, bv, ones_range(0, n));
    end
    // Ready: low while the second word waits, high again from the drain on.
    n_checks++;
    if ((rv & ones_range(1, n)) !== ones_range(l, n)) begin
      n_fail++;
      $display("FAIL b2b_ready dut%0d got=%h exp=%h", idx, rv & ones_range(1, n), ones_range(l, n));
    end
    @(negedge clk);
    check_idle("b2b_idle", idx);
  endtask

  task automatic test_reset_mid_frame();
    logic [511:0] tv, bv, rv, f0;
    logic [7:0]   w0, w1;
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    f0 = frame_model(0, w0);
    push(0, w0);
    push(0, w1);
    repeat (42) @(negedge clk);
    // Inside data bit 3 of the first frame, with the second word buffered.
    n_checks++;
    if (tx_sig[0] !== f0[43] || tx_busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pre dut0: tx=%b busy=%b ready=%b, required tx=%b busy=1 ready=0",
               tx_sig[0], tx_busy[0], in_ready[0], f0[43]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_ready_low: ready=%b, required 0000", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (tx_sig !== 4'hF || tx_busy !== 4'h0 || in_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_mid_frame: tx=%b busy=%b ready=%b, required tx=1111 busy=0000 ready=0000",
               tx_sig, tx_busy, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'hF) begin
      n_fail++;
      $display("FAIL rst_ready_after: ready=%b, required 1111", in_ready);
    end
    capture(0, 200, tv, bv, rv);
    n_checks++;
    if (tv !== ones_range(0, 200) || bv !== '0) begin
      n_fail++;
      $display("FAIL rst_no_resume: tx=%h busy=%h, required tx all high busy all low", tv, bv);
    end
  endtask

  task automatic test_handshake_hold();
    logic [511:0] tv, bv, rv, exp;
    logic [7:0]   w0, w1;
    int l;
    l  = frame_len(0);
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    fork
      begin
        push(0, w0);
        push(0, w1);
        in_data[0]  = 8'h11;
        in_valid[0] = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (in_ready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_ready_11: ready=%b, required 0", in_ready[0]);
        end
        in_data[0] = 8'h22;
        repeat (20) @(negedge clk);
        n_checks++;
        if (in_ready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_ready_22: ready=%b, required 0", in_ready[0]);
        end
        push(0, 8'h33);
      end
      begin
        @(negedge clk);
        capture(0, 3 * l, tv, bv, rv);
      end
    join
    exp = frame_model(0, w0) | (frame_model(0, w1) << l) | (frame_model(0, 8'h33) << (2 * l));
    n_checks++;
    if (tv !== exp) begin
      n_fail++;
      $display("FAIL hold_frames words=%02h,%02h,33 got=%h exp=%h", w0, w1, tv, exp);
    end
    @(negedge clk);
    check_idle("hold_idle", 0);
  endtask

  initial begin
    logic [511:0] tv;
    test_reset();
    test_single(0, 8'hA5, tv);
    test_back_to_back(0, 8'h00, 8'hFF);
    test_parity();
    test_reset_mid_frame();
    test_handshake_hold();
    for (int r = 0; r < 6; r++) begin
      test_single(int'($urandom_range(0, 3)), 8'($urandom), tv);
    end
    for (int r = 0; r < 4; r++) begin
      test_back_to_back(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
